// File: rtl/emergency_pkg.sv
// Shared types and default timing for the emergency dispatch path.
// State encoding is also used by the emergency state machines.
package emergency_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REPORT  = 2'b01,
        BACKOFF = 2'b10,
        FAILED  = 2'b11
    } state_e;

    localparam int N_SRC_DEF          = 4;
    localparam int ACK_TIMEOUT_DEF    = 5_000_000;
    localparam int BACKOFF_CYCLES_DEF = 2_500_000;
    localparam int MAX_RETRY_DEF      = 3;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/emergency_dispatcher_if.sv
// Detector/operator inputs and help-call link signals of the dispatcher.
// master = dispatcher side, slave = detectors, operator and link.
interface emergency_dispatcher_if #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
);
    logic [N_SRC-1:0] src_req;
    logic             user_clear;
    logic             comm_ack;
    logic             comm_req;
    logic [IDX_W-1:0] comm_code;
    logic [N_SRC-1:0] src_ack;
    logic [N_SRC-1:0] pending;
    logic             busy;
    logic             comm_fail;

    modport master (
        input  src_req, user_clear, comm_ack,
        output comm_req, comm_code, src_ack, pending, busy, comm_fail
    );

    modport slave (
        output src_req, user_clear, comm_ack,
        input  comm_req, comm_code, src_ack, pending, busy, comm_fail
    );
endinterface

// File: rtl/emergency_dispatcher_prio_pick.sv
// Lowest-index-first priority encoder over the pending event mask.
// Bit 0 is the most urgent source.
module prio_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

    assign valid = |req;
endmodule

// File: rtl/emergency_dispatcher.sv
// Latches detector alarms and reports the most urgent one over the help
// link with per-attempt timeout, fixed backoff and bounded retries.
module emergency_dispatcher
    import emergency_pkg::*;
#(
    parameter int N_SRC          = N_SRC_DEF,
    parameter int IDX_W          = $clog2(N_SRC),
    parameter int ACK_TIMEOUT    = ACK_TIMEOUT_DEF,
    parameter int BACKOFF_CYCLES = BACKOFF_CYCLES_DEF,
    parameter int MAX_RETRY      = MAX_RETRY_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    emergency_dispatcher_if.master bus
);
    localparam int TW = $clog2(imax(ACK_TIMEOUT, BACKOFF_CYCLES) + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BO_LAST   = TW'(BACKOFF_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_SRC-1:0] src_prev_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] rise;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    prio_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (pend_q),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign rise = bus.src_req & ~src_prev_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        idx_d   = idx_q;
        clr     = '0;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    retry_d = '0;
                    timer_d = '0;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                // ack wins even on the final timeout cycle
                if (bus.comm_ack) begin
                    clr[idx_q]   = 1'b1;
                    ack_d[idx_q] = 1'b1;
                    state_d      = IDLE;
                end else if (timer_q == ACK_LAST) begin
                    timer_d = '0;
                    state_d = (retry_q < RETRY_MAX) ? BACKOFF : FAILED;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BACKOFF: begin
                if (timer_q == BO_LAST) begin
                    retry_d = retry_q + 1'b1;
                    timer_d = '0;
                    state_d = REPORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FAILED: begin
                if (bus.user_clear) begin
                    clr[idx_q] = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // a fresh edge survives a same-cycle clear
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            retry_q    <= '0;
            idx_q      <= '0;
            src_prev_q <= '0;
            pend_q     <= '0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            idx_q      <= idx_d;
            src_prev_q <= bus.src_req;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.comm_req  = (state_q == REPORT);
    assign bus.comm_code = idx_q;
    assign bus.src_ack   = ack_q;
    assign bus.pending   = pend_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.comm_fail = (state_q == FAILED);
endmodule

// File: tb/tb_emergency_dispatcher.sv
// Directed and randomized checks of emergency_dispatcher against a
// bitmask/lowest-bit-first model of the alarm queue.
module tb_emergency_dispatcher;
    localparam int AT = 8;
    localparam int BC = 4;
    localparam int MR = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    emergency_dispatcher_if #(.N_SRC(4), .IDX_W(2)) bus();

    emergency_dispatcher #(
        .N_SRC          (4),
        .IDX_W          (2),
        .ACK_TIMEOUT    (AT),
        .BACKOFF_CYCLES (BC),
        .MAX_RETRY      (MR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowbit(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    initial begin
        logic [3:0] m, rem, n, bit_m;
        int first, failat, idx, d, adds, guard;
        logic hi, expv;

        reset          = 1'b1;
        bus.src_req    = '0;
        bus.user_clear = 1'b0;
        bus.comm_ack   = 1'b0;
        tick(); tick();
        chk("rst_req", bus.comm_req, 0);
        chk("rst_code", bus.comm_code, 0);
        chk("rst_sack", bus.src_ack, 0);
        chk("rst_pend", bus.pending, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fail", bus.comm_fail, 0);
        reset = 1'b0;
        tick(); tick();

        // single event on source 2
        bus.src_req = 4'b0100;
        tick();
        chk("s_pend", bus.pending, 4'b0100);
        chk("s_req0", bus.comm_req, 0);
        tick();
        chk("s_req1", bus.comm_req, 1);
        chk("s_code", bus.comm_code, 2);
        chk("s_busy", bus.busy, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("s_hold%0d", i), bus.comm_req, 1);
        end
        bus.comm_ack = 1'b1;
        tick();
        bus.comm_ack = 1'b0;
        chk("s_reqlo", bus.comm_req, 0);
        chk("s_sack", bus.src_ack, 4'b0100);
        chk("s_pend0", bus.pending, 0);
        tick();
        chk("s_sack_end", bus.src_ack, 0);
        bus.src_req = '0;
        tick();

        // priority: 1 before 3
        bus.src_req = 4'b1010;
        tick();
        chk("p_pend", bus.pending, 4'b1010);
        tick();
        chk("p_req_a", bus.comm_req, 1);
        chk("p_code_a", bus.comm_code, 1);
        tick();
        bus.comm_ack = 1'b1;
        tick();
        bus.comm_ack = 1'b0;
        chk("p_gap", bus.comm_req, 0);
        chk("p_sack_a", bus.src_ack, 4'b0010);
        chk("p_pend_a", bus.pending, 4'b1000);
        tick();
        chk("p_req_b", bus.comm_req, 1);
        chk("p_code_b", bus.comm_code, 3);
        tick();
        bus.comm_ack = 1'b1;
        tick();
        bus.comm_ack = 1'b0;
        chk("p_sack_b", bus.src_ack, 4'b1000);
        chk("p_pend_b", bus.pending, 0);
        bus.src_req = '0;
        tick();

        // retries then success on third attempt
        bus.src_req = 4'b0001;
        tick();
        for (int i = 0; i < 27; i++) begin
            tick();
            expv = (i < 8) || (i >= 12 && i < 20) || (i >= 24);
            chk($sformatf("r_pat%0d", i), bus.comm_req, expv);
        end
        bus.comm_ack = 1'b1;
        tick();
        bus.comm_ack = 1'b0;
        chk("r_sack", bus.src_ack, 4'b0001);
        chk("r_req", bus.comm_req, 0);
        chk("r_fail", bus.comm_fail, 0);
        bus.src_req = '0;
        tick();

        // ack on the timeout edge
        bus.src_req = 4'b0100;
        tick();
        for (int i = 0; i < AT; i++) tick();
        chk("t_lastreq", bus.comm_req, 1);
        bus.comm_ack = 1'b1;
        tick();
        bus.comm_ack = 1'b0;
        chk("t_busy", bus.busy, 0);
        chk("t_sack", bus.src_ack, 4'b0100);
        bus.src_req = '0;
        tick();

        // source re-rises on its own ack edge
        bus.src_req = 4'b0010;
        tick(); tick();
        chk("rr_req", bus.comm_req, 1);
        bus.src_req = '0;
        tick();
        bus.src_req  = 4'b0010;
        bus.comm_ack = 1'b1;
        tick();
        bus.comm_ack = 1'b0;
        chk("rr_sack", bus.src_ack, 4'b0010);
        chk("rr_pend", bus.pending, 4'b0010);
        tick();
        chk("rr_again", bus.comm_req, 1);
        chk("rr_code", bus.comm_code, 1);
        bus.comm_ack = 1'b1;
        tick();
        bus.comm_ack = 1'b0;
        chk("rr_pend0", bus.pending, 0);
        bus.src_req = '0;
        tick();

        // exhaustion and operator clear
        bus.src_req = 4'b0100;
        tick();
        first  = -1;
        failat = -1;
        for (int c = 0; c < 100 && failat < 0; c++) begin
            tick();
            if (first < 0 && bus.comm_req) first = c;
            if (bus.comm_fail) failat = c;
        end
        chk("x_time", failat - first, (1 + MR) * AT + MR * BC);
        chk("x_req", bus.comm_req, 0);
        chk("x_busy", bus.busy, 1);
        bus.src_req = 4'b0101;
        tick();
        chk("x_pend", bus.pending, 4'b0101);
        chk("x_stick", bus.comm_fail, 1);
        bus.user_clear = 1'b1;
        tick();
        bus.user_clear = 1'b0;
        chk("x_clr", bus.comm_fail, 0);
        chk("x_pend2", bus.pending, 4'b0001);
        chk("x_nosack", bus.src_ack, 0);
        tick();
        chk("x_req0", bus.comm_req, 1);
        chk("x_code0", bus.comm_code, 0);
        bus.comm_ack = 1'b1;
        tick();
        bus.comm_ack = 1'b0;
        chk("x_sack0", bus.src_ack, 4'b0001);
        bus.src_req = '0;
        tick();

        // reset during REPORT
        bus.src_req = 4'b1000;
        tick(); tick();
        chk("m_req", bus.comm_req, 1);
        reset = 1'b1;
        tick();
        chk("m_req0", bus.comm_req, 0);
        chk("m_code0", bus.comm_code, 0);
        chk("m_sack0", bus.src_ack, 0);
        chk("m_pend0", bus.pending, 0);
        chk("m_busy0", bus.busy, 0);
        chk("m_fail0", bus.comm_fail, 0);
        reset = 1'b0;
        tick();
        chk("m_relatch", bus.pending, 4'b1000);
        tick();
        chk("m_code", bus.comm_code, 3);
        bus.comm_ack = 1'b1;
        tick();
        bus.comm_ack = 1'b0;
        chk("m_sack", bus.src_ack, 4'b1000);
        bus.src_req = '0;
        tick();

        // randomized bursts against the bitmask model
        for (int t = 0; t < 25; t++) begin
            m = 4'($urandom_range(1, 15));
            bus.src_req = m;
            tick();
            chk("q_pend_in", bus.pending, m);
            bus.src_req = '0;
            rem   = m;
            adds  = 0;
            guard = 0;
            while (rem != 0 && guard < 16) begin
                guard++;
                idx = lowbit(rem);
                tick();
                chk("q_req", bus.comm_req, 1);
                chk("q_code", bus.comm_code, idx);
                d  = $urandom_range(0, AT - 1);
                hi = 1'b1;
                repeat (d) begin
                    tick();
                    hi &= bus.comm_req;
                end
                chk("q_hold", hi, 1);
                n = '0;
                if (adds < 2 && $urandom_range(0, 2) == 0) begin
                    n = 4'($urandom_range(0, 15));
                    adds++;
                end
                bus.src_req  = n;
                bus.comm_ack = 1'b1;
                tick();
                bus.comm_ack = 1'b0;
                bus.src_req  = '0;
                bit_m = 4'(1 << idx);
                rem   = (rem & ~bit_m) | n;
                chk("q_sack", bus.src_ack, bit_m);
                chk("q_pend", bus.pending, rem);
                chk("q_low", bus.comm_req, 0);
            end
            tick();
            chk("q_idle", bus.busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
